vc_input_buffer: RTL

VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

---
 rtl/noc_pkg.sv | 10 +
 rtl/vc_input_buffer_fifo.sv | 41 ++++
 rtl/vc_input_buffer.sv | 54 +++++
 3 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC constants (default flit width, idle flit, VC depth, VC ids).
package noc_pkg;
    localparam int NOC_FLIT_W = 8;
    localparam int VC_DEPTH = 4;
    localparam logic [7:0] IDLE_FLIT = 8'hFF;
    typedef enum logic {
        VC0 = 1'b0,
        VC1 = 1'b1
    } vc_id_e;
endpackage

// File: rtl/vc_input_buffer_fifo.sv
// vc_fifo: one virtual-channel FIFO; head reads as all-ones (idle) while empty.
// Memory is not reset; the head is masked by count so stale entries never leak out.
module vc_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = VC_DEPTH,
    parameter int FLIT_W = NOC_FLIT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [FLIT_W-1:0]          data,
    output logic [FLIT_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign do_pop = pop && count != '0;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head = count == '0 ? '1 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/vc_input_buffer.sv
// vc_input_buffer: two-VC input buffer steering flits into per-VC FIFOs, dropping on full.
// Optional VC_CREDIT_EN adds registered per-VC credit pulses one cycle after each pop.
module vc_input_buffer
    import noc_pkg::*;
#(
    parameter int DEPTH = VC_DEPTH,
    parameter int FLIT_W = NOC_FLIT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_vc,
    input  logic              rd_vc0,
    input  logic              rd_vc1,
    output logic [FLIT_W-1:0] vc0_out,
    output logic [FLIT_W-1:0] vc1_out,
    output logic              vc0_full,
    output logic              vc1_full,
    output logic              drop_err
`ifdef VC_CREDIT_EN
    ,
    output logic              credit_vc0,
    output logic              credit_vc1
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic is_flit, push0, push1, pop0_ok, pop1_ok;
    logic [CW-1:0] count0, count1;
    assign is_flit = flit_in != {FLIT_W{1'b1}};
    assign push0 = is_flit && vc_id_e'(flit_vc) == VC0;
    assign push1 = is_flit && vc_id_e'(flit_vc) == VC1;
    assign pop0_ok = rd_vc0 && count0 != '0;
    assign pop1_ok = rd_vc1 && count1 != '0;
    assign drop_err = !rst && ((push0 && vc0_full && !pop0_ok) || (push1 && vc1_full && !pop1_ok));
    vc_fifo #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) u_vc0 (
        .clk(clk), .rst(rst), .push(push0), .pop(rd_vc0), .data(flit_in),
        .head(vc0_out), .count(count0), .full(vc0_full)
    );
    vc_fifo #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) u_vc1 (
        .clk(clk), .rst(rst), .push(push1), .pop(rd_vc1), .data(flit_in),
        .head(vc1_out), .count(count1), .full(vc1_full)
    );
`ifdef VC_CREDIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_vc0 <= 1'b0;
            credit_vc1 <= 1'b0;
        end else begin
            credit_vc0 <= pop0_ok;
            credit_vc1 <= pop1_ok;
        end
    end
`endif
endmodule
